// File: rtl/ifu_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
// Single outstanding request: req/addr held until ack; rdata valid with ack.
interface ifu_if #(
    parameter int XLEN = 32
) ();
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ack;
    logic [31:0]     rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: sequential PC generation, single-outstanding imem
// fetch, small {instr, pc} FIFO to the execute stage, redirect with flush.
module ifu #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              FIFO_DEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    ifu_if.master           imem,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] curr_pc,
    output logic            instr_valid
);
    localparam int          PW  = $clog2(FIFO_DEPTH);
    localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REQ_DISCARD
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fifo_instr_q [FIFO_DEPTH];
    logic [31:0]     fifo_instr_d [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_pc_d    [FIFO_DEPTH];

    logic            pop;
    logic            push;
    logic [CW-1:0]   count_pop;
    logic [XLEN-1:0] target_pc;

    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : NOP;
    assign curr_pc     = instr_valid ? fifo_pc_q[rd_ptr_q] : fetch_pc_q;

    assign imem.req  = (state_q != IDLE);
    assign imem.addr = fetch_pc_q;

    assign pop       = instr_valid && !stall && !redirect;
    assign push      = (state_q == REQ) && imem.ack && !redirect;
    assign count_pop = count_q - CW'(pop);
    assign target_pc = redirect_pc & ~XLEN'(3);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;

        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            // An unacked request must keep its address; remember the target instead.
            if (state_q != IDLE && !imem.ack) begin
                pending_pc_d = target_pc;
                state_d      = REQ_DISCARD;
            end else begin
                fetch_pc_d = target_pc;
                state_d    = REQ;
            end
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                fifo_instr_d[wr_ptr_q] = imem.rdata;
                fifo_pc_d[wr_ptr_q]    = fetch_pc_q;
                wr_ptr_d               = wr_ptr_q + PW'(1);
                fetch_pc_d             = fetch_pc_q + XLEN'(4);
            end
            count_d = count_pop + CW'(push);

            unique case (state_q)
                IDLE: begin
                    if (count_pop < CW'(FIFO_DEPTH)) state_d = REQ;
                end
                REQ: begin
                    if (imem.ack) state_d = (count_d < CW'(FIFO_DEPTH)) ? REQ : IDLE;
                end
                REQ_DISCARD: begin
                    if (imem.ack) begin
                        fetch_pc_d = pending_pc_q;
                        state_d    = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_VECTOR;
            pending_pc_q <= RESET_VECTOR;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
    end
endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: sequential fetch, backpressure, redirects
// (idle, outstanding, coincident with ack), reset mid-discard, PC wrap.
module tb_ifu;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] curr_pc;
    logic        instr_valid;
    bit          auto_ack;
    int          vectors;
    int          miscompares;

    ifu_if #(.XLEN(32)) imem ();

    ifu #(.XLEN(32), .RESET_VECTOR(32'h0), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .instr       (instr),
        .curr_pc     (curr_pc),
        .instr_valid (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: answer in the same cycle with a word derived from the address.
    task automatic drive_mem();
        imem.ack   = imem.req;
        imem.rdata = imem.addr ^ K;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (auto_ack) drive_mem();
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        auto_ack = 1'b0; imem.ack = 1'b0; imem.rdata = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        auto_ack = 1'b0; imem.ack = 1'b0; imem.rdata = '0;
        cycle();
        cycle();
        vectors++;
        if ({imem.req, imem.addr, instr_valid, instr, curr_pc} !== {1'b0, 32'h0, 1'b0, NOP, 32'h0}) begin
            $display("FAIL reset_state: got req=%b addr=%h v=%b instr=%h pc=%h, want 0/0/0/%h/0",
                     imem.req, imem.addr, instr_valid, instr, curr_pc, NOP);
            miscompares++;
        end
        rst = 1'b0;
        cycle();
        vectors++;
        if ({imem.req, imem.addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
            $display("FAIL first_req: got req=%b addr=%h v=%b, want 1/00000000/0",
                     imem.req, imem.addr, instr_valid);
            miscompares++;
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pc;
        do_reset();
        auto_ack = 1'b1;
        drive_mem();
        for (int i = 1; i <= 6; i++) begin
            cycle();
            pc = 32'(4 * (i - 1));
            vectors++;
            if ({imem.addr, instr_valid, curr_pc, instr} !== {32'(4 * i), 1'b1, pc, pc ^ K}) begin
                $display("FAIL seq[%0d]: got addr=%h v=%b pc=%h instr=%h, want %h/1/%h/%h",
                         i, imem.addr, instr_valid, curr_pc, instr, 32'(4 * i), pc, pc ^ K);
                miscompares++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        auto_ack = 1'b1;
        drive_mem();
        cycle();
        cycle();
        stall = 1'b1;
        cycle();
        vectors++;
        if ({imem.req, instr_valid, curr_pc, instr} !== {1'b0, 1'b1, 32'h4, 32'h4 ^ K}) begin
            $display("FAIL bp_full: got req=%b v=%b pc=%h instr=%h, want 0/1/00000004/%h",
                     imem.req, instr_valid, curr_pc, instr, 32'h4 ^ K);
            miscompares++;
        end
        cycle();
        vectors++;
        if ({imem.req, curr_pc} !== {1'b0, 32'h4}) begin
            $display("FAIL bp_hold: got req=%b pc=%h, want 0/00000004", imem.req, curr_pc);
            miscompares++;
        end
        stall = 1'b0;
        cycle();
        vectors++;
        if ({imem.req, imem.addr, curr_pc, instr} !== {1'b1, 32'hC, 32'h8, 32'h8 ^ K}) begin
            $display("FAIL bp_resume: got req=%b addr=%h pc=%h instr=%h, want 1/0000000c/00000008/%h",
                     imem.req, imem.addr, curr_pc, instr, 32'h8 ^ K);
            miscompares++;
        end
        cycle();
        vectors++;
        if ({imem.addr, curr_pc, instr} !== {32'h10, 32'hC, 32'hC ^ K}) begin
            $display("FAIL bp_next: got addr=%h pc=%h instr=%h, want 00000010/0000000c/%h",
                     imem.addr, curr_pc, instr, 32'hC ^ K);
            miscompares++;
        end
    endtask

    task automatic test_redirect_idle();
        do_reset();
        auto_ack = 1'b1;
        drive_mem();
        repeat (3) cycle();
        stall = 1'b1;
        cycle();
        vectors++;
        if ({imem.req, instr_valid, curr_pc} !== {1'b0, 1'b1, 32'h8}) begin
            $display("FAIL rdi_setup: got req=%b v=%b pc=%h, want 0/1/00000008",
                     imem.req, instr_valid, curr_pc);
            miscompares++;
        end
        redirect = 1'b1; redirect_pc = 32'h103;
        cycle();
        redirect = 1'b0;
        vectors++;
        if ({instr_valid, imem.req, imem.addr} !== {1'b0, 1'b1, 32'h100}) begin
            $display("FAIL rdi_flush: got v=%b req=%b addr=%h, want 0/1/00000100",
                     instr_valid, imem.req, imem.addr);
            miscompares++;
        end
        cycle();
        vectors++;
        if ({instr_valid, curr_pc, instr} !== {1'b1, 32'h100, 32'h100 ^ K}) begin
            $display("FAIL rdi_first: got v=%b pc=%h instr=%h, want 1/00000100/%h",
                     instr_valid, curr_pc, instr, 32'h100 ^ K);
            miscompares++;
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        auto_ack = 1'b1;
        drive_mem();
        repeat (4) cycle();
        auto_ack = 1'b0; imem.ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            cycle();
            redirect = 1'b0;
            vectors++;
            if ({imem.req, imem.addr, instr_valid} !== {1'b1, 32'h10, 1'b0}) begin
                $display("FAIL rdo_hold[%0d]: got req=%b addr=%h v=%b, want 1/00000010/0",
                         i, imem.req, imem.addr, instr_valid);
                miscompares++;
            end
        end
        imem.ack = 1'b1; imem.rdata = 32'hDEAD_BEEF;
        cycle();
        vectors++;
        if ({imem.req, imem.addr, instr_valid} !== {1'b1, 32'h200, 1'b0}) begin
            $display("FAIL rdo_drop: got req=%b addr=%h v=%b, want 1/00000200/0",
                     imem.req, imem.addr, instr_valid);
            miscompares++;
        end
        auto_ack = 1'b1;
        drive_mem();
        cycle();
        vectors++;
        if ({instr_valid, curr_pc, instr} !== {1'b1, 32'h200, 32'h200 ^ K}) begin
            $display("FAIL rdo_first: got v=%b pc=%h instr=%h, want 1/00000200/%h",
                     instr_valid, curr_pc, instr, 32'h200 ^ K);
            miscompares++;
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        auto_ack = 1'b1;
        drive_mem();
        repeat (5) cycle();
        stall = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h40;
        cycle();
        redirect = 1'b0;
        vectors++;
        if ({instr_valid, imem.req, imem.addr} !== {1'b0, 1'b1, 32'h40}) begin
            $display("FAIL rda_drop: got v=%b req=%b addr=%h, want 0/1/00000040",
                     instr_valid, imem.req, imem.addr);
            miscompares++;
        end
        auto_ack = 1'b0; imem.ack = 1'b0;
        cycle();
        vectors++;
        if ({instr_valid, imem.addr} !== {1'b0, 32'h40}) begin
            $display("FAIL rda_empty: got v=%b addr=%h, want 0/00000040", instr_valid, imem.addr);
            miscompares++;
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto_ack = 1'b1;
        drive_mem();
        repeat (2) cycle();
        auto_ack = 1'b0; imem.ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h200;
        cycle();
        redirect_pc = 32'h300;
        cycle();
        redirect = 1'b0;
        vectors++;
        if ({imem.req, imem.addr} !== {1'b1, 32'h8}) begin
            $display("FAIL rm_hold: got req=%b addr=%h, want 1/00000008", imem.req, imem.addr);
            miscompares++;
        end
        imem.ack = 1'b1; imem.rdata = 32'hDEAD_BEEF;
        cycle();
        vectors++;
        if ({imem.addr, instr_valid} !== {32'h300, 1'b0}) begin
            $display("FAIL rm_overwrite: got addr=%h v=%b, want 00000300/0", imem.addr, instr_valid);
            miscompares++;
        end
        imem.ack = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h500;
        cycle();
        redirect = 1'b0;
        rst = 1'b1;
        cycle();
        vectors++;
        if ({imem.req, imem.addr, instr_valid, instr, curr_pc} !== {1'b0, 32'h0, 1'b0, NOP, 32'h0}) begin
            $display("FAIL rm_reset: got req=%b addr=%h v=%b instr=%h pc=%h, want 0/0/0/%h/0",
                     imem.req, imem.addr, instr_valid, instr, curr_pc, NOP);
            miscompares++;
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        auto_ack = 1'b1;
        drive_mem();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        vectors++;
        if ({imem.addr, instr_valid} !== {32'hFFFF_FFFC, 1'b0}) begin
            $display("FAIL wrap_redirect: got addr=%h v=%b, want fffffffc/0", imem.addr, instr_valid);
            miscompares++;
        end
        cycle();
        vectors++;
        if ({imem.addr, curr_pc, instr} !== {32'h0, 32'hFFFF_FFFC, 32'h5A5A_FFFC}) begin
            $display("FAIL wrap_pc: got addr=%h pc=%h instr=%h, want 00000000/fffffffc/5a5afffc",
                     imem.addr, curr_pc, instr);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_idle();
        test_redirect_outstanding();
        test_redirect_ack();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction fetch unit. Sits directly upstream of the integer execution unit.
- Generates sequential fetch addresses and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents the head as `instr`/`curr_pc`, gated by the downstream `stall`.
- Handles control-flow redirects by flushing buffered words and discarding in-flight responses.

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_VECTOR, 0, first fetch address after reset; must be 4-byte aligned.
- FIFO_DEPTH, 2, number of buffered {instr, pc} entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  downstream hold; head entry not consumed while high.
- redirect  input  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored and treated as 0.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address; stable while imem_req is high and not acked.
- imem_ack  input  1  response valid this cycle; only meaningful while imem_req is high.
- imem_rdata  input  32  instruction word; valid when imem_ack is high.
- instr  output  32  head instruction word presented to the decode/execute stage.
- curr_pc  output  XLEN  PC of the head instruction.
- instr_valid  output  1  head entry present.

Behaviour:
- **Reset.** Reset is synchronous and active-high on `rst`, sampled at posedge `clk`. While `rst` is high, or on the cycle after reset:
  - fetch_pc = RESET_VECTOR
  - FIFO empty, discard flag cleared, state IDLE
  - imem_req = 0, imem_addr = RESET_VECTOR, instr_valid = 0
  - instr = 32'h00000013 (NOP), curr_pc = RESET_VECTOR
  - Memory shares `rst`, so no stale ack exists after reset. Reset mid-request aborts the request unconditionally.
- **Outputs when FIFO empty.** instr = NOP and curr_pc = fetch_pc. These values are don't-care to consumers.
- **State machine (registered):** IDLE, REQ, REQ_DISCARD. imem_req = (state != IDLE). imem_addr = fetch_pc.
- **IDLE → REQ:** when the FIFO count after this cycle's pop is below FIFO_DEPTH. The first request is asserted in the first cycle after `rst` deasserts.
- **Ack in REQ:**
  - {imem_rdata, fetch_pc} is pushed to the FIFO and fetch_pc += 4 (wraps modulo 2^XLEN).
  - Next state is REQ if space remains after push and pop; otherwise IDLE.
  - Back-to-back acks yield one word per cycle.
- **Zero-wait ack allowed.** Ack may arrive in the first cycle of a request. The word is visible on `instr` in the following cycle (latency from ack to instr_valid = 1 cycle).
- **Pop:** occurs when instr_valid && !stall && !redirect. The next entry appears the following cycle.
- **Simultaneous push and pop:** count unchanged. Push into a full FIFO never occurs because a request is only issued with space available.
- **Redirect** has priority over push, pop and stall.
  - The FIFO is flushed (count = 0) at the clock edge.
  - State IDLE, or REQ with ack this cycle: the response (if any) is dropped, fetch_pc <= redirect_pc, and the next state is REQ.
  - State REQ with no ack: imem_addr holds its value (handshake rule). redirect_pc is stored in pending_pc and state becomes REQ_DISCARD.
- **REQ_DISCARD:**
  - On ack, the response is dropped, fetch_pc <= pending_pc, and the next state is REQ.
  - A further redirect in REQ_DISCARD overwrites pending_pc.
- **Handshake rule:** imem_req is never deasserted and imem_addr never changes before ack, except by `rst`.
- **Invariants:** at most one outstanding request; FIFO count never exceeds FIFO_DEPTH.

Test Plan:
- **Reset and sequential fetch.** Release `rst`, ack every cycle with rdata = addr ^ 32'hA5A5_0000, stall = 0. Required: imem_addr steps 0, 4, 8, …; instr_valid rises one cycle after the first ack; instr/curr_pc pairs match.
- **Backpressure.** Hold stall = 1 from cycle 3 with acks always high. Required: FIFO fills to 2 and imem_req drops to 0. On releasing stall, entries emerge in order with no loss or duplication, and fetch resumes at the next address.
- **Redirect with idle memory.** With a word at pc 0x8 buffered, pulse redirect with redirect_pc = 0x103. Required: instr_valid = 0 next cycle; the next imem_addr = 0x100; the first delivered curr_pc = 0x100.
- **Redirect during outstanding request.** Hold ack low for 3 cycles on addr 0x10, and pulse redirect to 0x200 in cycle 1. Required: imem_addr stays 0x10 until ack; that response is never delivered; the next request is at 0x200.
- **Redirect coincident with ack.** redirect to 0x40 and ack for 0x14 in the same cycle, with stall = 1. Required: the word for 0x14 is dropped, the FIFO is empty, and the next imem_addr = 0x40.
- **Reset mid-operation and wrap.** Assert `rst` while REQ_DISCARD is pending. Required: all outputs return to reset values the next cycle. Separately, redirect to 0xFFFF_FFFC with acks high: the next fetch address is 0x0000_0000.
